// File: rtl/dmem_pkg.sv
// Shared encodings for the LEGv8 memory stage: transfer sizes, writeback
// source select and the handshake FSM state type.
package dmem_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   localparam logic [1:0] WB_ALU   = 2'd0;
   localparam logic [1:0] WB_SHIFT = 2'd1;
   localparam logic [1:0] WB_MEM   = 2'd2;
   localparam logic [1:0] WB_ZERO  = 2'd3;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian byte-lane steering: byte enables and store data shifted into
// position, load data shifted down, truncated and sign/zero extended.
module dmem_lane_align
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W = 64
) (
   input  logic [$clog2(DATA_W/8)-1:0] off_i,
   input  logic [1:0]                  size_i,
   input  logic                        sign_ext_i,
   input  logic [DATA_W-1:0]           wdata_i,
   input  logic [DATA_W-1:0]           rdata_i,
   output logic [DATA_W/8-1:0]         be_o,
   output logic [DATA_W-1:0]           wdata_o,
   output logic [DATA_W-1:0]           rdata_o
);

   localparam int unsigned BE_W = DATA_W / 8;

   logic [BE_W-1:0]   mask;
   logic [DATA_W-1:0] shifted;

   always_comb begin
      case (size_i)
         SZ_B:    mask = BE_W'(1);
         SZ_H:    mask = BE_W'(3);
         SZ_W:    mask = BE_W'(15);
         default: mask = '1;
      endcase
      be_o    = mask << off_i;
      wdata_o = wdata_i << {off_i, 3'b000};
      shifted = rdata_i >> {off_i, 3'b000};

      // Size casts of a signed operand sign-extend, unsigned ones zero-extend.
      rdata_o = shifted;
      case (size_i)
         SZ_B: begin
            if (sign_ext_i) rdata_o = DATA_W'($signed(shifted[7:0]));
            else            rdata_o = DATA_W'(shifted[7:0]);
         end
         SZ_H: begin
            if (sign_ext_i) rdata_o = DATA_W'($signed(shifted[15:0]));
            else            rdata_o = DATA_W'(shifted[15:0]);
         end
         SZ_W: begin
            if (sign_ext_i) rdata_o = DATA_W'($signed(shifted[31:0]));
            else            rdata_o = DATA_W'(shifted[31:0]);
         end
         default: rdata_o = shifted;
      endcase
   end

endmodule

// File: rtl/dmem_stage_hs.sv
// LEGv8 memory stage: drives a req/ack data memory, stalls upstream while an
// access is outstanding and registers the writeback result.
module dmem_stage_hs
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned RD_W   = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   input  logic [RD_W-1:0]     in_rd,
   input  logic                in_reg_write,
   input  logic                in_mem_read,
   input  logic                in_mem_write,
   input  logic [1:0]          in_size,
   input  logic                in_sign_ext,
   input  logic [1:0]          in_sel2reg,
   input  logic [ADDR_W-1:0]   in_alu_out,
   input  logic [DATA_W-1:0]   in_shifter_out,
   input  logic [DATA_W-1:0]   in_db,
   output logic                stall,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                out_valid,
   output logic [RD_W-1:0]     out_rd,
   output logic                out_reg_write,
   output logic [DATA_W-1:0]   out_write_data,
   output logic                out_misalign
);

   localparam int unsigned OFF_W = $clog2(DATA_W / 8);

   state_t state_q, state_d;

   logic [RD_W-1:0]   l_rd_q;
   logic              l_reg_write_q, l_we_q, l_sign_q;
   logic [1:0]        l_size_q, l_sel_q;
   logic [ADDR_W-1:0] l_addr_q;
   logic [DATA_W-1:0] l_shf_q, l_db_q;

   logic              out_valid_q, out_valid_d;
   logic [RD_W-1:0]   out_rd_q, out_rd_d;
   logic              out_reg_write_q, out_reg_write_d;
   logic [DATA_W-1:0] out_write_data_q, out_write_data_d;
   logic              out_misalign_q, out_misalign_d;

   logic              mem_op, misalign, latch_en;
   logic [OFF_W-1:0]  off_in;
   logic [DATA_W-1:0] load_data;

   function automatic logic [DATA_W-1:0] wb_mux(input logic [1:0]        sel,
                                                input logic [ADDR_W-1:0] alu,
                                                input logic [DATA_W-1:0] shf,
                                                input logic [DATA_W-1:0] md);
      case (sel)
         WB_ALU:   return DATA_W'(alu);
         WB_SHIFT: return shf;
         WB_MEM:   return md;
         default:  return '0;
      endcase
   endfunction

   assign mem_op = in_mem_read | in_mem_write;
   assign off_in = in_alu_out[OFF_W-1:0];

   always_comb begin
      case (in_size)
         SZ_H:    misalign = off_in[0];
         SZ_W:    misalign = |off_in[1:0];
         SZ_D:    misalign = (DATA_W == 32) ? 1'b1 : |off_in;
         default: misalign = 1'b0;
      endcase
      misalign = misalign & mem_op;
   end

   // Lane steering works only from the latched fields, so the memory sees
   // stable request data for the whole WAIT period.
   dmem_lane_align #(.DATA_W(DATA_W)) u_lane (
      .off_i      (l_addr_q[OFF_W-1:0]),
      .size_i     (l_size_q),
      .sign_ext_i (l_sign_q),
      .wdata_i    (l_db_q),
      .rdata_i    (mem_rdata),
      .be_o       (mem_be),
      .wdata_o    (mem_wdata),
      .rdata_o    (load_data)
   );

   assign mem_we   = l_we_q;
   assign mem_addr = {l_addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

   always_comb begin
      state_d          = state_q;
      latch_en         = 1'b0;
      stall            = 1'b0;
      mem_req          = 1'b0;
      out_valid_d      = 1'b0;
      out_rd_d         = out_rd_q;
      out_reg_write_d  = out_reg_write_q;
      out_write_data_d = out_write_data_q;
      out_misalign_d   = out_misalign_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (mem_op && !misalign) begin
                  stall    = 1'b1;
                  latch_en = 1'b1;
                  state_d  = WAIT;
               end else begin
                  out_valid_d      = 1'b1;
                  out_rd_d         = in_rd;
                  out_reg_write_d  = in_reg_write & ~misalign;
                  out_write_data_d = wb_mux(in_sel2reg, in_alu_out, in_shifter_out, '0);
                  out_misalign_d   = misalign;
               end
            end
         end
         WAIT: begin
            mem_req = 1'b1;
            stall   = ~mem_ack;
            if (mem_ack) begin
               out_valid_d      = 1'b1;
               out_rd_d         = l_rd_q;
               out_reg_write_d  = l_reg_write_q;
               out_write_data_d = wb_mux(l_sel_q, l_addr_q, l_shf_q, load_data);
               out_misalign_d   = 1'b0;
               state_d          = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= IDLE;
         out_valid_q      <= 1'b0;
         out_rd_q         <= '0;
         out_reg_write_q  <= 1'b0;
         out_write_data_q <= '0;
         out_misalign_q   <= 1'b0;
      end else begin
         state_q          <= state_d;
         out_valid_q      <= out_valid_d;
         out_rd_q         <= out_rd_d;
         out_reg_write_q  <= out_reg_write_d;
         out_write_data_q <= out_write_data_d;
         out_misalign_q   <= out_misalign_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         l_rd_q        <= '0;
         l_reg_write_q <= 1'b0;
         l_we_q        <= 1'b0;
         l_sign_q      <= 1'b0;
         l_size_q      <= '0;
         l_sel_q       <= '0;
         l_addr_q      <= '0;
         l_shf_q       <= '0;
         l_db_q        <= '0;
      end else if (latch_en) begin
         l_rd_q        <= in_rd;
         l_reg_write_q <= in_reg_write;
         l_we_q        <= in_mem_write;
         l_sign_q      <= in_sign_ext;
         l_size_q      <= in_size;
         l_sel_q       <= in_sel2reg;
         l_addr_q      <= in_alu_out;
         l_shf_q       <= in_shifter_out;
         l_db_q        <= in_db;
      end
   end

   assign out_valid      = out_valid_q;
   assign out_rd         = out_rd_q;
   assign out_reg_write  = out_reg_write_q;
   assign out_write_data = out_write_data_q;
   assign out_misalign   = out_misalign_q;

endmodule

// File: tb/tb_dmem_stage_hs.sv
// Bench for dmem_stage_hs: byte-array reference memory plus a separate
// responder memory written only through the DUT's byte enables.
module tb_dmem_stage_hs;
   import dmem_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   // 64-bit instance
   logic        a_in_valid, a_in_reg_write, a_in_mem_read, a_in_mem_write, a_in_sign_ext;
   logic [4:0]  a_in_rd;
   logic [1:0]  a_in_size, a_in_sel2reg;
   logic [63:0] a_in_alu_out, a_in_shifter_out, a_in_db;
   logic        a_stall, a_mem_req, a_mem_we, a_mem_ack;
   logic [63:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
   logic [7:0]  a_mem_be;
   logic        a_out_valid, a_out_reg_write, a_out_misalign;
   logic [4:0]  a_out_rd;
   logic [63:0] a_out_write_data;

   // 32-bit instance
   logic        b_in_valid, b_in_reg_write, b_in_mem_read, b_in_mem_write, b_in_sign_ext;
   logic [4:0]  b_in_rd;
   logic [1:0]  b_in_size, b_in_sel2reg;
   logic [31:0] b_in_alu_out, b_in_shifter_out, b_in_db;
   logic        b_stall, b_mem_req, b_mem_we, b_mem_ack;
   logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
   logic [3:0]  b_mem_be;
   logic        b_out_valid, b_out_reg_write, b_out_misalign;
   logic [4:0]  b_out_rd;
   logic [31:0] b_out_write_data;

   dmem_stage_hs #(.DATA_W(64), .ADDR_W(64), .RD_W(5)) u_dut64 (
      .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_rd(a_in_rd),
      .in_reg_write(a_in_reg_write), .in_mem_read(a_in_mem_read),
      .in_mem_write(a_in_mem_write), .in_size(a_in_size), .in_sign_ext(a_in_sign_ext),
      .in_sel2reg(a_in_sel2reg), .in_alu_out(a_in_alu_out),
      .in_shifter_out(a_in_shifter_out), .in_db(a_in_db), .stall(a_stall),
      .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_be(a_mem_be),
      .mem_wdata(a_mem_wdata), .mem_ack(a_mem_ack), .mem_rdata(a_mem_rdata),
      .out_valid(a_out_valid), .out_rd(a_out_rd), .out_reg_write(a_out_reg_write),
      .out_write_data(a_out_write_data), .out_misalign(a_out_misalign)
   );

   dmem_stage_hs #(.DATA_W(32), .ADDR_W(32), .RD_W(5)) u_dut32 (
      .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_rd(b_in_rd),
      .in_reg_write(b_in_reg_write), .in_mem_read(b_in_mem_read),
      .in_mem_write(b_in_mem_write), .in_size(b_in_size), .in_sign_ext(b_in_sign_ext),
      .in_sel2reg(b_in_sel2reg), .in_alu_out(b_in_alu_out),
      .in_shifter_out(b_in_shifter_out), .in_db(b_in_db), .stall(b_stall),
      .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_be(b_mem_be),
      .mem_wdata(b_mem_wdata), .mem_ack(b_mem_ack), .mem_rdata(b_mem_rdata),
      .out_valid(b_out_valid), .out_rd(b_out_rd), .out_reg_write(b_out_reg_write),
      .out_write_data(b_out_write_data), .out_misalign(b_out_misalign)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] ref_mem  [0:65535];
   logic [7:0] resp_mem [0:65535];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rd_resp(input logic [63:0] a);
      logic [63:0] r;
      for (int j = 0; j < 8; j++) r[8*j +: 8] = resp_mem[a[15:0] + j];
      return r;
   endfunction

   // One instruction through the 64-bit DUT; expectations come from the
   // byte-level reference memory and the transfer rules.
   task automatic op64(input logic rd_en, input logic wr_en, input logic [1:0] sz,
                       input logic sx, input logic [1:0] sel, input logic [63:0] addr,
                       input logic [63:0] shf, input logic [63:0] db, input logic [4:0] rd,
                       input logic rw, input int lat);
      int          n     = 1 << sz;
      int          off   = int'(addr[2:0]);
      logic        memop = rd_en | wr_en;
      logic        mis   = memop && ((off % n) != 0);
      logic [63:0] v     = '0;
      logic [63:0] exp_wd;
      logic        wd_ok = 1'b1;
      logic [15:0] be16;
      logic [63:0] wmask;

      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[addr[15:0] + i];
      if (sx) for (int i = 8*n; i < 64; i++) v[i] = v[8*n-1];
      case (sel)
         2'd0: exp_wd = addr;
         2'd1: exp_wd = shf;
         2'd3: exp_wd = '0;
         default: begin
            if (!memop) exp_wd = '0;
            else if (!wr_en && !mis) exp_wd = v;
            else begin exp_wd = '0; wd_ok = 1'b0; end
         end
      endcase
      be16 = ((16'd1 << n) - 16'd1) << off;

      @(posedge clk); #1;
      a_in_valid = 1'b1; a_in_mem_read = rd_en; a_in_mem_write = wr_en;
      a_in_size = sz; a_in_sign_ext = sx; a_in_sel2reg = sel; a_in_alu_out = addr;
      a_in_shifter_out = shf; a_in_db = db; a_in_rd = rd; a_in_reg_write = rw;
      a_mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("issue.stall", a_stall, memop && !mis);
      chk("issue.mem_req", a_mem_req, 1'b0);
      @(posedge clk); #1;
      a_in_valid = 1'b0; a_mem_ack = 1'b0;
      if (!memop || mis) begin
         chk("op1.out_valid", a_out_valid, 1'b1);
         chk("op1.out_rd", a_out_rd, rd);
         chk("op1.out_reg_write", a_out_reg_write, rw && !mis);
         chk("op1.out_misalign", a_out_misalign, mis);
         if (wd_ok) chk("op1.out_write_data", a_out_write_data, exp_wd);
         chk("op1.mem_req", a_mem_req, 1'b0);
      end else begin
         a_in_alu_out = {$urandom, $urandom}; a_in_db = {$urandom, $urandom};
         a_in_size = 2'($urandom_range(0, 3)); a_in_mem_write = ~wr_en;
         chk("mem.bubble", a_out_valid, 1'b0);
         for (int k = 0; k <= lat; k++) begin
            chk("mem.req", a_mem_req, 1'b1);
            chk("mem.we", a_mem_we, wr_en);
            chk("mem.addr", a_mem_addr, {addr[63:3], 3'b000});
            chk("mem.be", a_mem_be, be16[7:0]);
            chk("mem.wdata", a_mem_wdata, db << (8*off));
            if (k == lat) break;
            @(negedge clk);
            chk("wait.stall", a_stall, 1'b1);
            @(posedge clk); #1;
         end
         a_mem_ack = 1'b1;
         a_mem_rdata = rd_resp(a_mem_addr);
         if (a_mem_we)
            for (int j = 0; j < 8; j++)
               if (a_mem_be[j]) resp_mem[a_mem_addr[15:0] + j] = a_mem_wdata[8*j +: 8];
         @(negedge clk);
         chk("ack.stall", a_stall, 1'b0);
         @(posedge clk); #1;
         a_mem_ack = 1'b0; a_mem_rdata = {$urandom, $urandom};
         chk("mem.out_valid", a_out_valid, 1'b1);
         chk("mem.out_rd", a_out_rd, rd);
         chk("mem.out_reg_write", a_out_reg_write, rw);
         chk("mem.out_misalign", a_out_misalign, 1'b0);
         if (wd_ok) chk("mem.out_write_data", a_out_write_data, exp_wd);
         chk("mem.req_drop", a_mem_req, 1'b0);
         if (wr_en) for (int i = 0; i < n; i++) ref_mem[addr[15:0] + i] = db[8*i +: 8];
      end
      wmask = '0;
   endtask

   initial begin
      logic [1:0]  sz, sel;
      int          kind, n, off, lat;
      logic [63:0] base;

      for (int i = 0; i < 65536; i++) begin
         ref_mem[i]  = 8'($urandom);
         resp_mem[i] = ref_mem[i];
      end
      {a_in_valid, a_in_reg_write, a_in_mem_read, a_in_mem_write, a_in_sign_ext} = '0;
      a_in_rd = '0; a_in_size = '0; a_in_sel2reg = '0; a_in_alu_out = '0;
      a_in_shifter_out = '0; a_in_db = '0; a_mem_ack = 1'b0; a_mem_rdata = '0;
      {b_in_valid, b_in_reg_write, b_in_mem_read, b_in_mem_write, b_in_sign_ext} = '0;
      b_in_rd = '0; b_in_size = '0; b_in_sel2reg = '0; b_in_alu_out = '0;
      b_in_shifter_out = '0; b_in_db = '0; b_mem_ack = 1'b0; b_mem_rdata = '0;

      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst.out_valid", a_out_valid, 1'b0);
      chk("rst.out_rd", a_out_rd, 5'd0);
      chk("rst.out_reg_write", a_out_reg_write, 1'b0);
      chk("rst.out_write_data", a_out_write_data, 64'd0);
      chk("rst.out_misalign", a_out_misalign, 1'b0);
      chk("rst.mem_req", a_mem_req, 1'b0);
      chk("rst.stall", a_stall, 1'b0);
      chk("rst32.out_valid", b_out_valid, 1'b0);

      // ALU op, then an idle cycle that must hold everything but out_valid
      op64(0, 0, SZ_D, 0, WB_ALU, 64'h10, 64'h5, 64'h0, 5'd3, 1, 0);
      @(posedge clk); #1;
      chk("hold.out_valid", a_out_valid, 1'b0);
      chk("hold.out_rd", a_out_rd, 5'd3);
      chk("hold.out_write_data", a_out_write_data, 64'h10);
      chk("hold.out_reg_write", a_out_reg_write, 1'b1);

      // Signed byte load from a prepared block
      for (int i = 0; i < 8; i++) begin ref_mem[16'h1000 + i] = 8'h00; resp_mem[16'h1000 + i] = 8'h00; end
      ref_mem[16'h1005] = 8'h80; resp_mem[16'h1005] = 8'h80;
      op64(1, 0, SZ_B, 1, WB_MEM, 64'h1005, 64'h0, 64'h0, 5'd4, 1, 3);
      chk("sb.value", a_out_write_data, 64'hFFFF_FFFF_FFFF_FF80);

      // Halfword store, then read back through the responder memory
      op64(0, 1, SZ_H, 0, WB_ALU, 64'h2006, 64'h0, 64'hABCD, 5'd0, 0, 0);
      op64(1, 0, SZ_H, 0, WB_MEM, 64'h2006, 64'h0, 64'h0, 5'd6, 1, 1);
      chk("sh.readback", a_out_write_data, 64'hABCD);

      // Misaligned word load
      op64(1, 0, SZ_W, 0, WB_MEM, 64'h3002, 64'h0, 64'h0, 5'd7, 1, 0);

      // Reset while waiting for ack, then a late ack
      @(posedge clk); #1;
      a_in_valid = 1'b1; a_in_mem_read = 1'b1; a_in_mem_write = 1'b0; a_in_size = SZ_D;
      a_in_alu_out = 64'h4000; a_in_sel2reg = WB_MEM; a_in_reg_write = 1'b1;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      chk("rstw.req", a_mem_req, 1'b1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rstw.req_drop", a_mem_req, 1'b0);
      chk("rstw.stall", a_stall, 1'b0);
      chk("rstw.out_valid", a_out_valid, 1'b0);
      a_mem_ack = 1'b1;
      @(posedge clk); #1;
      a_mem_ack = 1'b0;
      chk("rstw.late_ack", a_out_valid, 1'b0);
      chk("rstw.late_req", a_mem_req, 1'b0);
      op64(0, 0, SZ_D, 0, WB_SHIFT, 64'h77, 64'h1234_5678_9ABC_DEF0, 64'h0, 5'd9, 1, 0);

      // Randomised mix of ALU, load, store and read+write ops
      for (int t = 0; t < 150; t++) begin
         sz   = 2'($urandom_range(0, 3));
         n    = 1 << sz;
         kind = $urandom_range(0, 3);
         base = 64'($urandom_range(0, 8191)) * 64'd8;
         off  = $urandom_range(0, 1) ? $urandom_range(0, 7) : ($urandom_range(0, 7) / n) * n;
         lat  = $urandom_range(0, 4);
         if (kind >= 2) begin
            sel = 2'($urandom_range(0, 2));
            if (sel == 2'd2) sel = WB_ZERO;
         end else sel = 2'($urandom_range(0, 3));
         op64(kind == 1 || kind == 3, kind >= 2, sz, 1'($urandom_range(0, 1)), sel,
              base + 64'(off), {$urandom, $urandom}, {$urandom, $urandom},
              5'($urandom), 1'($urandom_range(0, 1)), lat);
      end

      // 32-bit instance: doubleword is always misaligned
      @(posedge clk); #1;
      b_in_valid = 1'b1; b_in_mem_read = 1'b1; b_in_size = SZ_D; b_in_alu_out = 32'h8;
      b_in_sel2reg = WB_MEM; b_in_reg_write = 1'b1; b_in_rd = 5'd2;
      @(negedge clk);
      chk("w32d.stall", b_stall, 1'b0);
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      chk("w32d.out_valid", b_out_valid, 1'b1);
      chk("w32d.misalign", b_out_misalign, 1'b1);
      chk("w32d.reg_write", b_out_reg_write, 1'b0);
      chk("w32d.mem_req", b_mem_req, 1'b0);

      // 32-bit zero-extended word load
      b_in_valid = 1'b1; b_in_size = SZ_W; b_in_sign_ext = 1'b0; b_in_alu_out = 32'h4; b_in_rd = 5'd7;
      @(negedge clk);
      chk("w32w.stall", b_stall, 1'b1);
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      chk("w32w.req", b_mem_req, 1'b1);
      chk("w32w.addr", b_mem_addr, 32'h4);
      chk("w32w.be", b_mem_be, 4'hF);
      b_mem_ack = 1'b1; b_mem_rdata = 32'h8765_4321;
      @(posedge clk); #1;
      b_mem_ack = 1'b0;
      chk("w32w.out_valid", b_out_valid, 1'b1);
      chk("w32w.data", b_out_write_data, 32'h8765_4321);
      chk("w32w.rd", b_out_rd, 5'd7);

      // 32-bit signed halfword load from the upper lanes
      b_in_valid = 1'b1; b_in_size = SZ_H; b_in_sign_ext = 1'b1; b_in_alu_out = 32'h6; b_in_rd = 5'd8;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      chk("w32h.addr", b_mem_addr, 32'h4);
      chk("w32h.be", b_mem_be, 4'hC);
      b_mem_ack = 1'b1; b_mem_rdata = 32'h8001_1234;
      @(posedge clk); #1;
      b_mem_ack = 1'b0;
      chk("w32h.data", b_out_write_data, 32'hFFFF_8001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_stage_hs.md
Name: dmem_stage_hs

Overview:
- Parametrised memory stage for the pipelined LEGv8 core. It sits between the EX/MEM and MEM/WB pipeline registers and drives an external data memory over a req/ack handshake, so memory latency can vary.
- It supports byte, half, word and double transfers, with little-endian byte lanes and sign or zero extension on loads. It detects misaligned accesses.
- It selects the writeback data, stalls upstream while a memory access is outstanding, and registers its outputs toward writeback.

Parameters:
- DATA_W, 64, data and register width. Legal values are 32 and 64.
- ADDR_W, 64, byte address width.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  an instruction is presented this cycle.
- in_rd  in  RD_W  destination register.
- in_reg_write  in  1  the instruction writes the register file.
- in_mem_read  in  1  load.
- in_mem_write  in  1  store.
- in_size  in  2  transfer size: 0=1B, 1=2B, 2=4B, 3=8B.
- in_sign_ext  in  1  load result is sign-extended (0 = zero-extended).
- in_sel2reg  in  2  writeback source: 0=ALU, 1=shifter, 2=memory, 3=zero.
- in_alu_out  in  ADDR_W  ALU result, also the memory address.
- in_shifter_out  in  DATA_W  shifter result.
- in_db  in  DATA_W  store data.
- stall  out  1  upstream must hold its outputs.
- mem_req  out  1  memory request.
- mem_we  out  1  request is a write.
- mem_addr  out  ADDR_W  address aligned to a DATA_W/8 boundary.
- mem_be  out  DATA_W/8  byte enables.
- mem_wdata  out  DATA_W  lane-shifted store data.
- mem_ack  in  1  request completed; mem_rdata is valid this cycle.
- mem_rdata  in  DATA_W  full-width read data.
- out_valid  out  1  registered result is valid.
- out_rd  out  RD_W  registered destination register.
- out_reg_write  out  1  registered register-write enable.
- out_write_data  out  DATA_W  registered writeback data.
- out_misalign  out  1  alignment fault flag.

Behaviour:
- Reset: state=IDLE. All out_* registers are 0. mem_req=0 and stall=0.
- Memory op: in_mem_read | in_mem_write. If both are set, the access is treated as a write and the read is ignored.
- Offset: off = addr[log2(DATA_W/8)-1:0].
- Misaligned when either holds:
  - off is not a multiple of 2^in_size;
  - in_size=3 while DATA_W=32.
- FSM states: IDLE, WAIT.
- IDLE, non-memory op or misaligned memory op:
  - Captured into the out_* registers at the next edge; latency 1.
  - No stall.
  - A misaligned op raises out_misalign=1, forces out_reg_write=0 and issues no mem_req.
- IDLE, aligned memory op:
  - stall=1 combinationally.
  - All in_* fields are latched at the edge and the FSM goes to WAIT.
  - out_valid=0 at the next edge, inserting a bubble.
- WAIT:
  - mem_req=1, driven from the latched fields; mem_we, mem_addr, mem_be and mem_wdata are held stable until ack.
  - in_* inputs are ignored.
  - stall = !mem_ack.
  - On mem_ack, the out_* registers load the result at the edge, out_valid=1, and the FSM returns to IDLE.
- Minimum memory-op latency is 2 cycles (ack in the first WAIT cycle).
- mem_ack while in IDLE is ignored.
- Byte lanes:
  - mem_be = ((1<<2^size)-1) << off.
  - mem_wdata = in_db << (8*off).
  - Load data = mem_rdata >> (8*off), truncated to 2^size bytes, then extended to DATA_W per the latched in_sign_ext.
- Writeback mux follows in_sel2reg. A non-memory op with sel2reg=2 produces 0.
- out_valid follows in_valid for 1-cycle ops.
- While in_valid=0 in IDLE: out_valid=0 and the other out_* registers hold their values.
- Reset in WAIT: the FSM returns to IDLE and mem_req drops the following cycle, with no ack required. A late ack after reset is ignored.

Decomposition:
- Shared package dmem_pkg: the size encoding constants (SZ_B, SZ_H, SZ_W, SZ_D), the sel2reg encoding (WB_ALU, WB_SHIFT, WB_MEM, WB_ZERO) and the state_t enum.
- One sub-module: dmem_lane_align, a combinational block. It computes mem_be, mem_wdata and the extracted, extended load data from off, size and sign_ext.

Test Plan:
- Non-memory op: sel2reg=0, alu_out=0x10, rd=3 -> next cycle out_valid=1, out_write_data=0x10, out_rd=3, stall never asserted.
- Signed byte load: addr=0x1005, size=0, sign_ext=1, ack after 3 WAIT cycles, mem_rdata=0x0000_8000_0000_0000 -> mem_be=0x20, mem_addr=0x1000, stall for 4 cycles, out_write_data=0xFFFF_FFFF_FFFF_FF80.
- Halfword store: addr=0x2006, size=1, db=0xABCD, ack in the first WAIT cycle -> mem_we=1, mem_be=0xC0, mem_wdata=0xABCD_0000_0000_0000, latency 2.
- Misaligned word load: addr=0x3002, size=2 -> no mem_req, out_misalign=1, out_reg_write=0, no stall.
- Reset during WAIT -> mem_req drops the following cycle, out_valid=0, a subsequent ALU op completes normally.
- DATA_W=32 instance: size=3 -> out_misalign=1. A zero-extended word load at addr=0x4 returns mem_rdata unchanged.
